// File: rtl/mul4_pkg.sv
// Shared constants and types for the 2x2 multiplier tournament scorer.
// Lane i of every 16-bit word carries operands a = i[3:2] and b = i[1:0].
// The stimulus words enumerate all 16 operand pairs. The EXP words hold
// the exact product bits for those lanes.
package mul4_pkg;

    localparam logic [15:0] A1 = 16'hFF00;
    localparam logic [15:0] A0 = 16'hF0F0;
    localparam logic [15:0] B1 = 16'hCCCC;
    localparam logic [15:0] B0 = 16'hAAAA;

    localparam logic [15:0] EXP3 = 16'h8000;
    localparam logic [15:0] EXP2 = 16'h4C00;
    localparam logic [15:0] EXP1 = 16'h6AC0;
    localparam logic [15:0] EXP0 = 16'hA0A0;

    localparam int SCORE_W = 7;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SCORE,
        UPDATE,
        DONE
    } state_e;

endpackage

// File: rtl/mul4_lane_popcount.sv
// Counts the lanes in which a 16-bit response word matches its expected word.
// Ports:
//   y         in   16  candidate response word
//   exp       in   16  expected product word
//   match_cnt out  5   number of matching lanes, 0..16
module mul4_lane_popcount (
    input  logic [15:0] y,
    input  logic [15:0] exp,
    output logic [4:0]  match_cnt
);

    logic [15:0] match;

    assign match = ~(y ^ exp);

    always_comb begin
        match_cnt = '0;
        for (int i = 0; i < 16; i++) begin
            match_cnt = match_cnt + 5'(match[i]);
        end
    end

endmodule

// File: rtl/mul4_tournament_scorer.sv
// Drives exhaustive stimulus to a bank of evolved 2x2 multipliers, steps an
// external mux through every candidate, scores each response word against
// the exact product and reports the best candidate.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   start                       begin a tournament (only accepted in IDLE)
//   a1, a0, b1, b0              constant stimulus words
//   cand_sel                    candidate currently driven through the mux
//   y3..y0                      response of the selected candidate
//   busy, done                  run status, one-cycle completion pulse
//   winner_idx, winner_score,   result of the last completed tournament
//   perfect
//
// state  | meaning
// IDLE   | waiting for start; running results cleared
// DRIVE  | cand_sel held while the candidate response settles
// SCORE  | four cycles, one response word (y0..y3) accumulated per cycle
// UPDATE | compare against best so far, advance to next candidate
// DONE   | one cycle, done pulse with winner outputs freshly loaded
module mul4_tournament_scorer
    import mul4_pkg::*;
#(
    parameter  int N_CAND   = 4,
    parameter  int RESP_LAT = 1,
    localparam int SEL_W    = $clog2(N_CAND)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [15:0]        a1,
    output logic [15:0]        a0,
    output logic [15:0]        b1,
    output logic [15:0]        b0,
    output logic [SEL_W-1:0]   cand_sel,
    input  logic [15:0]        y3,
    input  logic [15:0]        y2,
    input  logic [15:0]        y1,
    input  logic [15:0]        y0,
    output logic               busy,
    output logic               done,
    output logic [SEL_W-1:0]   winner_idx,
    output logic [SCORE_W-1:0] winner_score,
    output logic               perfect
);

    localparam int                 LAT_W    = $clog2(RESP_LAT + 1);
    localparam logic [LAT_W-1:0]   LAT_INIT = LAT_W'(RESP_LAT - 1);
    localparam logic [SEL_W-1:0]   LAST_SEL = SEL_W'(N_CAND - 1);
    localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(64);

    state_e             state_q;
    logic [SEL_W-1:0]   cand_sel_q;
    logic [LAT_W-1:0]   lat_cnt_q;
    logic [1:0]         step_q;
    logic [SCORE_W-1:0] acc_q;
    logic [SCORE_W-1:0] best_score_q;
    logic [SEL_W-1:0]   best_idx_q;
    logic               busy_q;
    logic               done_q;
    logic [SEL_W-1:0]   winner_idx_q;
    logic [SCORE_W-1:0] winner_score_q;
    logic               perfect_q;

    logic [15:0]        word_y;
    logic [15:0]        word_exp;
    logic [4:0]         match_cnt;
    logic [SCORE_W-1:0] acc_d;
    logic               take_best;
    logic [SCORE_W-1:0] best_score_d;
    logic [SEL_W-1:0]   best_idx_d;

    assign a1 = A1;
    assign a0 = A0;
    assign b1 = B1;
    assign b0 = B0;

    always_comb begin
        word_y   = y0;
        word_exp = EXP0;
        case (step_q)
            2'd1: begin word_y = y1; word_exp = EXP1; end
            2'd2: begin word_y = y2; word_exp = EXP2; end
            2'd3: begin word_y = y3; word_exp = EXP3; end
            default: ;
        endcase
    end

    mul4_lane_popcount u_popcount (
        .y         (word_y),
        .exp       (word_exp),
        .match_cnt (match_cnt)
    );

    assign acc_d = acc_q + SCORE_W'(match_cnt);

    // Strict greater-than keeps ties on the lowest index; the first
    // candidate always seeds the best-so-far.
    assign take_best    = (acc_q > best_score_q) || (cand_sel_q == '0);
    assign best_score_d = take_best ? acc_q : best_score_q;
    assign best_idx_d   = take_best ? cand_sel_q : best_idx_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cand_sel_q     <= '0;
            lat_cnt_q      <= '0;
            step_q         <= '0;
            acc_q          <= '0;
            best_score_q   <= '0;
            best_idx_q     <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            winner_idx_q   <= '0;
            winner_score_q <= '0;
            perfect_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cand_sel_q   <= '0;
                    acc_q        <= '0;
                    best_score_q <= '0;
                    best_idx_q   <= '0;
                    if (start) begin
                        state_q   <= DRIVE;
                        busy_q    <= 1'b1;
                        lat_cnt_q <= LAT_INIT;
                    end
                end
                DRIVE: begin
                    if (lat_cnt_q == '0) begin
                        state_q <= SCORE;
                        step_q  <= '0;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - LAT_W'(1);
                    end
                end
                SCORE: begin
                    acc_q  <= acc_d;
                    step_q <= step_q + 2'd1;
                    if (step_q == 2'd3) begin
                        state_q <= UPDATE;
                    end
                end
                UPDATE: begin
                    acc_q        <= '0;
                    best_score_q <= best_score_d;
                    best_idx_q   <= best_idx_d;
                    if (cand_sel_q == LAST_SEL) begin
                        // Winner is loaded from the just-updated best so it
                        // is valid in the same cycle as the done pulse.
                        state_q        <= DONE;
                        busy_q         <= 1'b0;
                        done_q         <= 1'b1;
                        winner_idx_q   <= best_idx_d;
                        winner_score_q <= best_score_d;
                        perfect_q      <= (best_score_d == MAX_SCORE);
                    end else begin
                        cand_sel_q <= cand_sel_q + SEL_W'(1);
                        lat_cnt_q  <= LAT_INIT;
                        state_q    <= DRIVE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cand_sel     = cand_sel_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign winner_idx   = winner_idx_q;
    assign winner_score = winner_score_q;
    assign perfect      = perfect_q;

endmodule
